pwm_deadtime: RTL and testbench

- Downstream stage of pwm_gen. Consumes the single-ended PWM waveform and produces a complementary high-side/low-side gate-drive pair.
- Inserts a programmable break-before-make dead time on every edge.
- Provides a latched fault shutdown.
- Sits between pwm_gen and the chip pads, in the same clk domain.

---
 rtl/pwm_deadtime.sv | 104 ++++++++++
 tb/tb_pwm_deadtime.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage: turns a single-ended PWM into a high/low-side
// pair with programmable break-before-make dead time and a latched fault shutdown.
module pwm_deadtime #(
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  input  logic                en,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault,
  input  logic                fault_clr,
  output logic                out_hi,
  output logic                out_lo,
  output logic                dead_active,
  output logic                fault_latched
);

  typedef enum logic [2:0] {
    S_OFF,
    S_LO,
    S_DEAD_TO_HI,
    S_HI,
    S_DEAD_TO_LO,
    S_FAULT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pwm_q;
  logic [DT_WIDTH-1:0] r_dt_cnt;
  logic [DT_WIDTH-1:0] w_dt_cnt_nxt;
  logic                w_dt_zero;
  logic [DT_WIDTH-1:0] w_dt_load;

  assign w_dt_zero = (dead_time == '0);
  assign w_dt_load = dead_time - DT_WIDTH'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_dt_cnt_nxt = r_dt_cnt;
    if (fault) begin
      w_state_nxt = S_FAULT;
    end else if (r_state == S_FAULT) begin
      if (fault_clr) w_state_nxt = S_OFF;
    end else if (!en) begin
      w_state_nxt = S_OFF;
    end else begin
      case (r_state)
        // Leaving OFF always takes a full dead interval toward the current input level.
        S_OFF: begin
          if (w_dt_zero) begin
            w_state_nxt = r_pwm_q ? S_HI : S_LO;
          end else begin
            w_state_nxt  = r_pwm_q ? S_DEAD_TO_HI : S_DEAD_TO_LO;
            w_dt_cnt_nxt = w_dt_load;
          end
        end
        S_LO: begin
          if (r_pwm_q) begin
            w_state_nxt  = w_dt_zero ? S_HI : S_DEAD_TO_HI;
            w_dt_cnt_nxt = w_dt_zero ? r_dt_cnt : w_dt_load;
          end
        end
        S_HI: begin
          if (!r_pwm_q) begin
            w_state_nxt  = w_dt_zero ? S_LO : S_DEAD_TO_LO;
            w_dt_cnt_nxt = w_dt_zero ? r_dt_cnt : w_dt_load;
          end
        end
        // An input reversal mid-interval falls back to the side that was safe all along.
        S_DEAD_TO_HI: begin
          if (!r_pwm_q)              w_state_nxt  = S_LO;
          else if (r_dt_cnt == '0)   w_state_nxt  = S_HI;
          else                       w_dt_cnt_nxt = r_dt_cnt - DT_WIDTH'(1);
        end
        S_DEAD_TO_LO: begin
          if (r_pwm_q)               w_state_nxt  = S_HI;
          else if (r_dt_cnt == '0)   w_state_nxt  = S_LO;
          else                       w_dt_cnt_nxt = r_dt_cnt - DT_WIDTH'(1);
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_pwm_q  <= 1'b0;
      r_dt_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pwm_q  <= pwm_in;
      r_dt_cnt <= w_dt_cnt_nxt;
    end
  end

  assign out_lo        = (r_state == S_LO);
  assign out_hi        = (r_state == S_HI);
  assign dead_active   = (r_state == S_DEAD_TO_HI) || (r_state == S_DEAD_TO_LO);
  assign fault_latched = (r_state == S_FAULT);

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios plus random traffic, every cycle
// compared against a target-side / remaining-dead-cycles model.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic       en = 1'b0;
  logic [7:0] dead_time = '0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       out_hi, out_lo, dead_active, fault_latched;

  pwm_deadtime #(.DT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .en(en), .dead_time(dead_time),
    .fault(fault), .fault_clr(fault_clr), .out_hi(out_hi), .out_lo(out_lo),
    .dead_active(dead_active), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int dead_seen = 0;
  int hi_seen = 0;

  // Model: driving (m_act) toward side m_tgt, with m_left dead cycles still to go.
  bit m_q = 0, m_flt = 0, m_act = 0, m_tgt = 0;
  int m_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge(input bit p, input bit e, input bit f, input bit fc,
                            input bit r, input int d);
    bit q;
    q = m_q;
    m_q = p;
    if (r) begin
      m_q = 0; m_flt = 0; m_act = 0; m_left = 0;
    end else if (f) begin
      m_flt = 1; m_act = 0;
    end else if (m_flt) begin
      if (fc) m_flt = 0;
    end else if (!e) begin
      m_act = 0;
    end else if (!m_act) begin
      m_act = 1; m_tgt = q; m_left = d;
    end else if (m_left > 0) begin
      if (q != m_tgt) begin m_tgt = q; m_left = 0; end
      else m_left--;
    end else if (q != m_tgt) begin
      m_tgt = q; m_left = d;
    end
  endtask

  task automatic step(input bit p, input bit e, input bit f, input bit fc,
                      input bit r, input int d);
    logic [3:0] exp;
    @(negedge clk);
    pwm_in = p; en = e; fault = f; fault_clr = fc; rst = r; dead_time = 8'(d);
    @(posedge clk);
    model_edge(p, e, f, fc, r, d);
    #1;
    exp = {m_act && m_left == 0 && m_tgt, m_act && m_left == 0 && !m_tgt,
           m_act && m_left > 0, m_flt};
    check("outputs", {out_hi, out_lo, dead_active, fault_latched}, exp);
    check("no_overlap", out_hi & out_lo, 0);
    dead_seen += int'(dead_active);
    hi_seen   += int'(out_hi);
  endtask

  initial begin
    bit p;
    // reset
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("reset_outs", {out_hi, out_lo, dead_active, fault_latched}, 0);

    // enable with low input, dead_time 3
    dead_seen = 0;
    repeat (6) step(0, 1, 0, 0, 0, 3);
    check("enable_dead_cycles", dead_seen, 3);
    check("enable_lo", out_lo, 1);

    // rising edge, dead_time 4
    dead_seen = 0;
    repeat (8) step(1, 1, 0, 0, 0, 4);
    check("rise_dead_cycles", dead_seen, 4);
    check("rise_hi", out_hi, 1);

    // zero dead time falling edge
    dead_seen = 0;
    repeat (4) step(0, 1, 0, 0, 0, 0);
    check("zero_dt_dead", dead_seen, 0);
    check("zero_dt_lo", out_lo, 1);

    // short pulse swallowed
    hi_seen = 0;
    repeat (2) step(1, 1, 0, 0, 0, 5);
    repeat (10) step(0, 1, 0, 0, 0, 5);
    check("short_pulse_hi", hi_seen, 0);
    check("short_pulse_lo", out_lo, 1);

    // fault in HI, then clear
    repeat (6) step(1, 1, 0, 0, 0, 2);
    check("pre_fault_hi", out_hi, 1);
    step(1, 1, 1, 0, 0, 2);
    check("fault_latch", {out_hi, out_lo, fault_latched}, 3'b001);
    repeat (3) step(1, 0, 0, 0, 0, 2);
    check("fault_held", fault_latched, 1);
    step(1, 1, 0, 1, 0, 2);
    check("fault_clr_off", {out_hi, out_lo, dead_active, fault_latched}, 0);
    repeat (6) step(1, 1, 0, 0, 0, 2);
    check("post_fault_hi", out_hi, 1);

    // disable mid dead interval, then re-enable
    repeat (3) step(0, 1, 0, 0, 0, 6);
    step(0, 0, 0, 0, 0, 6);
    check("disable_dead", dead_active, 0);
    dead_seen = 0;
    repeat (8) step(0, 1, 0, 0, 0, 6);
    check("reenable_dead", dead_seen, 6);
    check("reenable_lo", out_lo, 1);

    // random traffic
    p = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) p = ~p;
      step(p, $urandom_range(0, 29) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0,
           ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
